// File: rtl/mlp_dispatch_sched_if.sv
// rtl/mlp_dispatch_sched_if.sv - stream, dispatcher and collector signals of mlp_dispatch_sched
interface mlp_dispatch_sched_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_DISP   = 4
);
    logic [DATA_WIDTH-1:0]          s_axis_tdata;
    logic                           s_axis_tvalid;
    logic                           s_axis_tready;
    logic [NUM_DISP*DATA_WIDTH-1:0] dispatcher_ififo_wdata;
    logic [NUM_DISP-1:0]            dispatcher_ififo_wen;
    logic [NUM_DISP-1:0]            dispatcher_ififo_rdy;
    logic [DATA_WIDTH-1:0]          collector_ofifo_rdata;
    logic                           collector_ofifo_ren;
    logic                           collector_ofifo_rdy;
    logic [DATA_WIDTH-1:0]          m_axis_tdata;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;

    // Scheduler side
    modport master (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output dispatcher_ififo_wdata, dispatcher_ififo_wen,
        input  dispatcher_ififo_rdy,
        input  collector_ofifo_rdata, collector_ofifo_rdy,
        output collector_ofifo_ren,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready
    );

    // Environment side: input source, FIFOs and result sink
    modport slave (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  dispatcher_ififo_wdata, dispatcher_ififo_wen,
        output dispatcher_ififo_rdy,
        output collector_ofifo_rdata, collector_ofifo_rdy,
        input  collector_ofifo_ren,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/mlp_dispatch_sched.sv
// rtl/mlp_dispatch_sched.sv - round-robin burst dispatcher and collector drain for mlp_1
module mlp_dispatch_sched #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_DISP   = 4,
    parameter int BURST_LEN  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_rounds,
    input  logic [CNT_WIDTH-1:0] num_results,
    output logic                 busy,
    output logic                 done,
    mlp_dispatch_sched_if.master bus
);
    localparam int WORD_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int DIDX_W = $clog2(NUM_DISP);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(BURST_LEN - 1);
    localparam logic [DIDX_W-1:0] DISP_LAST = DIDX_W'(NUM_DISP - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      word_cnt_q, word_cnt_d;
    logic [DIDX_W-1:0]      cur_q, cur_d;
    logic [CNT_WIDTH-1:0]   round_cnt_q, round_cnt_d;
    logic [CNT_WIDTH-1:0]   issued_q, issued_d;
    logic [CNT_WIDTH-1:0]   result_cnt_q, result_cnt_d;
    logic [CNT_WIDTH-1:0]   num_rounds_q, num_rounds_d;
    logic [CNT_WIDTH-1:0]   num_results_q, num_results_d;
    logic                   inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]  skid0_q, skid0_d;
    logic [DATA_WIDTH-1:0]  skid1_q, skid1_d;
    logic [1:0]             skid_cnt_q, skid_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic active, s_ready, fire, ren, push, pop;

    // Zero-latency dispatch path and collector/result strobes
    always_comb begin
        active  = (state_q == DISPATCH) || (state_q == DRAIN);
        s_ready = (state_q == DISPATCH) && bus.dispatcher_ififo_rdy[cur_q];
        fire    = bus.s_axis_tvalid && s_ready;
        // Inflight read plus buffered words must leave room in the 2-entry skid
        ren     = active && bus.collector_ofifo_rdy
                  && (({1'b0, inflight_q} + skid_cnt_q) < 2'd2)
                  && (issued_q < num_results_q);
        push    = inflight_q;
        pop     = (skid_cnt_q != 2'd0) && bus.m_axis_tready;

        bus.s_axis_tready          = s_ready;
        bus.dispatcher_ififo_wen   = fire ? (NUM_DISP'(1) << cur_q) : '0;
        bus.dispatcher_ififo_wdata = (state_q == DISPATCH) ? {NUM_DISP{bus.s_axis_tdata}} : '0;
        bus.collector_ofifo_ren    = ren;
        bus.m_axis_tvalid          = (skid_cnt_q != 2'd0);
        bus.m_axis_tdata           = skid0_q;
        busy                       = busy_q;
        done                       = done_q;
    end

    // Next-state logic for the FSM, dispatch counters and skid buffer
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        cur_d         = cur_q;
        round_cnt_d   = round_cnt_q;
        issued_d      = issued_q;
        result_cnt_d  = result_cnt_q;
        num_rounds_d  = num_rounds_q;
        num_results_d = num_results_q;
        inflight_d    = ren;
        skid0_d       = skid0_q;
        skid1_d       = skid1_q;
        skid_cnt_d    = skid_cnt_q;

        if (ren) issued_d = issued_q + 1'b1;
        if (pop) result_cnt_d = result_cnt_q + 1'b1;

        // Head is always skid0; a pop shifts skid1 forward before the push lands
        if (push && pop) begin
            if (skid_cnt_q == 2'd1) begin
                skid0_d = bus.collector_ofifo_rdata;
            end else begin
                skid0_d = skid1_q;
                skid1_d = bus.collector_ofifo_rdata;
            end
        end else if (push) begin
            if (skid_cnt_q == 2'd0) skid0_d = bus.collector_ofifo_rdata;
            else                    skid1_d = bus.collector_ofifo_rdata;
            skid_cnt_d = skid_cnt_q + 2'd1;
        end else if (pop) begin
            skid0_d    = skid1_q;
            skid_cnt_d = skid_cnt_q - 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_rounds_d  = num_rounds;
                    num_results_d = num_results;
                    word_cnt_d    = '0;
                    cur_d         = '0;
                    round_cnt_d   = '0;
                    issued_d      = '0;
                    result_cnt_d  = '0;
                    state_d       = (num_rounds == '0) ? DRAIN : DISPATCH;
                end
            end
            DISPATCH: begin
                if (fire) begin
                    if (word_cnt_q == WORD_LAST) begin
                        word_cnt_d = '0;
                        if (cur_q == DISP_LAST) begin
                            cur_d       = '0;
                            round_cnt_d = round_cnt_q + 1'b1;
                            if (round_cnt_d == num_rounds_q) state_d = DRAIN;
                        end else begin
                            cur_d = cur_q + 1'b1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if ((result_cnt_q == num_results_q) && (skid_cnt_q == 2'd0)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DISPATCH) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // State registers; reset abandons any run in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            cur_q         <= '0;
            round_cnt_q   <= '0;
            issued_q      <= '0;
            result_cnt_q  <= '0;
            num_rounds_q  <= '0;
            num_results_q <= '0;
            inflight_q    <= 1'b0;
            skid0_q       <= '0;
            skid1_q       <= '0;
            skid_cnt_q    <= 2'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            cur_q         <= cur_d;
            round_cnt_q   <= round_cnt_d;
            issued_q      <= issued_d;
            result_cnt_q  <= result_cnt_d;
            num_rounds_q  <= num_rounds_d;
            num_results_q <= num_results_d;
            inflight_q    <= inflight_d;
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
            skid_cnt_q    <= skid_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: tb/tb_mlp_dispatch_sched.sv
// tb/tb_mlp_dispatch_sched.sv - self-checking bench for mlp_dispatch_sched
module tb_mlp_dispatch_sched;
    localparam int DW = 64;
    localparam int ND = 4;
    localparam int BL = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_rounds;
    logic [CW-1:0] num_results;
    logic          busy;
    logic          done;

    mlp_dispatch_sched_if #(.DATA_WIDTH(DW), .NUM_DISP(ND)) bus ();

    mlp_dispatch_sched #(
        .DATA_WIDTH(DW), .NUM_DISP(ND), .BURST_LEN(BL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .num_rounds(num_rounds), .num_results(num_results),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: words still to send, collector contents, results owed downstream
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] coll_q[$];
    logic [DW-1:0] exp_res[$];
    int  sent, total, issued, popped, n_res, coll_feed;
    bit  running, done_pending, ren_prev;
    int  valid_pct = 100;
    int  ready_pct = 100;
    bit  toggle_ready = 1'b0;
    bit  rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        in_q.delete(); coll_q.delete(); exp_res.delete();
        sent = 0; total = 0; issued = 0; popped = 0; n_res = 0; coll_feed = 0;
        running = 1'b0; done_pending = 1'b0; ren_prev = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then drive next inputs after the rising edge
    task automatic cycle();
        int d, occ;
        bit exp_done, exp_tready, fire, ren_exp;
        logic [ND-1:0] exp_wen;
        @(negedge clk);
        exp_done = done_pending;
        if (exp_done) running = 1'b0;
        check("done", done, exp_done);
        check("busy", busy, running);
        done_pending = running && (sent == total) && (popped == n_res);

        // Word k of a run belongs to dispatcher (k / BURST_LEN) mod NUM_DISP
        d = (sent / BL) % ND;
        exp_tready = running && (sent < total) && bus.dispatcher_ififo_rdy[d];
        check("s_axis_tready", bus.s_axis_tready, exp_tready);
        fire = exp_tready && bus.s_axis_tvalid;
        exp_wen = fire ? (ND'(1) << d) : '0;
        check("wen", bus.dispatcher_ififo_wen, exp_wen);
        if (fire) begin
            check("wdata", bus.dispatcher_ififo_wdata[d*DW +: DW], in_q[0]);
            void'(in_q.pop_front());
            sent++;
        end

        // Issued-but-unpopped words are either in flight or buffered
        occ = issued - popped - int'(ren_prev);
        check("m_axis_tvalid", bus.m_axis_tvalid, occ > 0);
        if (occ > 0) check("m_axis_tdata", bus.m_axis_tdata, exp_res[0]);
        ren_exp = running && bus.collector_ofifo_rdy && (issued - popped < 2) && (issued < n_res);
        check("collector_ofifo_ren", bus.collector_ofifo_ren, ren_exp);
        if (occ > 0 && bus.m_axis_tready) begin
            void'(exp_res.pop_front());
            popped++;
        end

        @(posedge clk);
        #1;
        ren_prev = ren_exp;
        if (ren_exp) begin
            bus.collector_ofifo_rdata = coll_q.pop_front();
            exp_res.push_back(bus.collector_ofifo_rdata);
            issued++;
        end
        if (coll_feed > 0 && $urandom_range(0, 2) == 0) begin
            coll_q.push_back({$urandom, $urandom});
            coll_feed--;
        end
        bus.collector_ofifo_rdy = (coll_q.size() != 0);
        bus.s_axis_tvalid = (in_q.size() != 0) && ($urandom_range(0, 99) < valid_pct);
        bus.s_axis_tdata  = (in_q.size() != 0) ? in_q[0] : {$urandom, $urandom};
        if (toggle_ready) bus.m_axis_tready = ~bus.m_axis_tready;
        else              bus.m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        if (rand_rdy) begin
            for (int i = 0; i < ND; i++) bus.dispatcher_ififo_rdy[i] = ($urandom_range(0, 99) < 70);
        end
    endtask

    task automatic do_start(input int rounds, input int results);
        num_rounds  = CW'(rounds);
        num_results = CW'(results);
        start = 1'b1;
        cycle();
        start = 1'b0;
        running = 1'b1; total = rounds * BL * ND; n_res = results;
        sent = 0; issued = 0; popped = 0; done_pending = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (running && n < budget) begin
            cycle();
            n++;
        end
        vectors++;
        assert (!running) else begin
            miscompares++;
            $error("FAIL run_timeout observed=still_running expected=done_within_%0d_cycles", budget);
        end
    endtask

    task automatic wait_sent(input int target, input int budget);
        int n = 0;
        while (sent < target && n < budget) begin
            cycle();
            n++;
        end
        vectors++;
        assert (sent >= target) else begin
            miscompares++;
            $error("FAIL wait_sent observed=%0d expected=%0d", sent, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_rounds = '0; num_results = '0;
        bus.s_axis_tdata = 64'h0123_4567_89ab_cdef; bus.s_axis_tvalid = 1'b1;
        bus.dispatcher_ififo_rdy = '1; bus.collector_ofifo_rdy = 1'b0;
        bus.collector_ofifo_rdata = '0; bus.m_axis_tready = 1'b1;
        model_reset();

        // Reset state: every output low, even with an input word offered
        cycle();
        check("reset_wdata_zero", |bus.dispatcher_ififo_wdata, 1'b0);
        check("reset_m_axis_tdata", bus.m_axis_tdata, '0);
        reset = 1'b0;
        cycle();

        // One round, burst of two per dispatcher, words 1..8
        for (int i = 1; i <= 8; i++) in_q.push_back(DW'(i));
        do_start(1, 0);
        run_until_done(100);
        cycle();

        // Dispatcher 1 stalls mid-burst for five cycles
        for (int i = 0; i < 8; i++) in_q.push_back(DW'(64'h11 + i));
        do_start(1, 0);
        wait_sent(3, 50);
        bus.dispatcher_ififo_rdy[1] = 1'b0;
        repeat (5) cycle();
        bus.dispatcher_ififo_rdy = '1;
        run_until_done(100);

        // Three collector results drained with a toggling downstream ready
        coll_q.push_back(64'hA1A1_0000_0000_0001);
        coll_q.push_back(64'hB2B2_0000_0000_0002);
        coll_q.push_back(64'hC3C3_0000_0000_0003);
        bus.collector_ofifo_rdy = 1'b1;
        toggle_ready = 1'b1;
        do_start(0, 3);
        run_until_done(100);
        toggle_ready = 1'b0;
        repeat (2) cycle();

        // Nothing to dispatch or collect: DONE two cycles after start
        do_start(0, 0);
        run_until_done(3);
        repeat (2) cycle();

        // Reset during round 1 of 3 with the skid buffer backed up
        for (int i = 0; i < 24; i++) in_q.push_back({$urandom, $urandom});
        coll_q.push_back(64'h5555_0000_0000_0001);
        coll_q.push_back(64'h5555_0000_0000_0002);
        bus.collector_ofifo_rdy = 1'b1;
        ready_pct = 0;
        do_start(3, 2);
        wait_sent(10, 100);
        reset = 1'b1;
        model_reset();
        bus.s_axis_tvalid = 1'b0;
        bus.collector_ofifo_rdy = 1'b0;
        cycle();
        reset = 1'b0;
        ready_pct = 100;
        cycle();
        for (int i = 0; i < 8; i++) in_q.push_back(DW'(64'h700 + i));
        do_start(1, 0);
        run_until_done(100);

        // Start pulsed again mid-dispatch with different counts must be ignored
        for (int i = 0; i < 16; i++) in_q.push_back(DW'(64'h900 + i));
        do_start(2, 0);
        wait_sent(5, 50);
        num_rounds = CW'(5); num_results = CW'(7);
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_until_done(200);

        // Randomized runs: source gaps, dispatcher stalls, backpressure, trickling collector
        for (int r = 0; r < 6; r++) begin
            int rounds, results;
            rounds  = int'($urandom_range(1, 3));
            results = int'($urandom_range(0, 6));
            for (int i = 0; i < rounds * BL * ND; i++) in_q.push_back({$urandom, $urandom});
            coll_feed = results;
            valid_pct = int'($urandom_range(40, 100));
            ready_pct = int'($urandom_range(30, 100));
            rand_rdy  = 1'b1;
            do_start(rounds, results);
            run_until_done(3000);
            rand_rdy = 1'b0;
            bus.dispatcher_ififo_rdy = '1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mlp_dispatch_sched.md
Name: mlp_dispatch_sched

Overview:
- Scheduler between a single AXI-stream input source and the four dispatcher input FIFOs of mlp_1, plus the drain path from the mlp_1 collector output FIFO.
- Splits the input stream into bursts of BURST_LEN words per dispatcher and sends them round-robin, dispatcher 0..NUM_DISP-1, for a programmed number of rounds.
- Pops collector results (1-cycle read latency) into an AXI-stream master through a 2-entry skid buffer, and signals done once all rounds are dispatched and all results are collected.

Parameters:
- DATA_WIDTH, 64, width of dispatcher write data, collector read data and both AXI-stream data buses.
- NUM_DISP, 4, number of dispatcher ififos; must be at least 2.
- BURST_LEN, 8, words written to one dispatcher before moving to the next; must be at least 1.
- CNT_WIDTH, 16, width of the round and result counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; accepted only in IDLE.
- num_rounds  in  CNT_WIDTH  rounds to dispatch; sampled on accepted start; 0 means no dispatch.
- num_results  in  CNT_WIDTH  collector words expected; sampled on accepted start.
- busy  out  1  high in DISPATCH and DRAIN.
- done  out  1  one-cycle pulse in DONE.
- s_axis_tdata  in  DATA_WIDTH  input words.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- dispatcher_ififo_wdata  out  NUM_DISP*DATA_WIDTH  slice i goes to dispatcher i.
- dispatcher_ififo_wen  out  NUM_DISP  per-dispatcher write enable.
- dispatcher_ififo_rdy  in  NUM_DISP  per-dispatcher ififo ready (not full).
- collector_ofifo_rdata  in  DATA_WIDTH  collector read data; valid 1 cycle after ren.
- collector_ofifo_ren  out  1  collector read enable.
- collector_ofifo_rdy  in  1  collector FIFO non-empty.
- m_axis_tdata  out  DATA_WIDTH  result words.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0, skid buffer empty. Reset mid-operation abandons the run; words already written to the FIFOs are not tracked.
- FSM states and transitions:
  - IDLE: start moves to DISPATCH; if num_rounds is 0, go straight to DRAIN.
  - DISPATCH: moves to DRAIN when the last word of the last round is written.
  - DRAIN: moves to DONE when the result count equals num_results and the skid buffer is empty.
  - DONE: lasts 1 cycle, then IDLE.
  - start is ignored outside IDLE.
- Dispatch datapath, combinational pass-through with zero latency:
  - s_axis_tready = (state==DISPATCH) & dispatcher_ififo_rdy[cur].
  - dispatcher_ififo_wen[cur] = s_axis_tvalid & s_axis_tready; every other wen bit is 0.
  - All wdata slices carry s_axis_tdata.
- Dispatch counters:
  - word_cnt counts 0..BURST_LEN-1. On the last word of a burst, cur wraps NUM_DISP-1 back to 0.
  - round_cnt increments when cur wraps.
  - A stall on dispatcher cur blocks input entirely; the scheduler never skips to another dispatcher.
- Collection runs in DISPATCH and DRAIN:
  - collector_ofifo_ren = collector_ofifo_rdy & (inflight + skid occupancy < 2) & (issued < num_results).
  - The registered ren produces rdata the next cycle, which is pushed into the 2-entry skid buffer. m_axis takes data from the buffer head.
  - result_cnt increments on each m_axis handshake (tvalid & tready).
  - m_axis_tvalid must not drop without a handshake, and tdata must stay stable while tvalid is high and tready is low.
  - In IDLE and DONE, ren is 0.
- Boundaries:
  - Simultaneous skid push and pop keeps occupancy unchanged.
  - Counters are compared with equality only and do not wrap within a run.
  - num_results = 0 gives DRAIN → DONE without any reads.

Test Plan:
- BURST_LEN=2, num_rounds=1, all rdy=1, 8 input words 0x1..0x8 → dispatcher0 gets 1,2; dispatcher1 gets 3,4; dispatcher2 gets 5,6; dispatcher3 gets 7,8. Then DRAIN, with one wen per cycle.
- Drop rdy[1] for 5 cycles in the middle of dispatcher1's burst → s_axis_tready=0 for those 5 cycles, no wen asserted, no words lost or reordered.
- num_results=3, collector holds 3 words, m_axis_tready toggling 1/0 → m_axis emits the 3 words in order with no duplicates, tdata stable while stalled, and done pulses exactly once afterwards.
- num_rounds=0, num_results=0, start → DONE 2 cycles after start, then IDLE; ren never asserted.
- Assert reset for 1 cycle in the middle of DISPATCH (round 1 of 3) → all outputs 0 immediately, FSM in IDLE; a following start re-begins at dispatcher0, word 0.
- Pulse start again while in DISPATCH → ignored; round count and the dispatch sequence are unchanged.
